hog_pixel_feeder: RTL
=====================

Name: hog_pixel_feeder

Overview:
Source side of the HOG pixel handshake. It reads a stored frame from word-addressed pixel memory and streams it into the hog engine's ready/request/i_data interface, four pixels per beat in raster order. A small prefetch FIFO hides memory read latency, so the feeder sustains one beat per cycle while the consumer holds request high. Frame-level start/done control is exposed to the system controller.

Parameters:
PIX_W, 8, pixel width
IMG_W, 640, frame width in pixels; must be a multiple of 4
IMG_H, 480, frame height in pixels
MEM_AW, 17, memory word address width; must be >= ceil(log2(IMG_W*IMG_H/4))
FIFO_D, 4, prefetch FIFO depth; power of two, >= 2
(local) IN_W = 4*PIX_W; N_WORDS = IMG_W*IMG_H/4

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
start  in  1  pulse that begins a frame; ignored while busy=1
abort  in  1  pulse that cancels the current frame
base_addr  in  MEM_AW  frame base word address; sampled when start is accepted
mem_rd  out  1  memory read strobe
mem_addr  out  MEM_AW  memory read address
mem_rdata  in  IN_W  read data; valid exactly 1 cycle after mem_rd
request  in  1  consumer can take a beat this cycle
ready  out  1  beat valid this cycle
o_data  out  IN_W  four pixels; pixel 0 (leftmost) in bits [PIX_W-1:0]
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the last beat of a frame is delivered

Behaviour:
- Reset values: every output 0; FSM in IDLE; FIFO empty; counters cleared.
- Handshake: ready = request AND FIFO not empty. This is combinational from request and the registered FIFO state. o_data = FIFO head.
  - A beat transfers in every cycle where ready=1. The FIFO pops on that edge.
  - No beat is offered unless requested. request may drop at any time with no data loss.
- FSM states:
  - IDLE: busy=0. On start go to FETCH: latch base_addr, issue_cnt=0, sent_cnt=0.
  - FETCH: busy=1. Issue mem_rd with mem_addr = base + issue_cnt when (fifo_count + inflight) < FIFO_D. inflight (0/1) is the previous-cycle mem_rd.
    - On an issue edge issue_cnt increments.
    - When issue_cnt reaches N_WORDS, go to DRAIN. No further mem_rd is issued.
  - DRAIN: busy=1. Wait until sent_cnt reaches N_WORDS, then go to IDLE. done pulses in the first IDLE cycle.
- Write path: mem_rdata is pushed into the FIFO in the cycle after mem_rd. Credit accounting guarantees the push never overflows.
- Simultaneous push and pop in the same cycle: count is unchanged and both take effect.
- Throughput: the first ready is possible 2 cycles after start is accepted (issue, then push). After that, one beat per cycle while request=1 continuously.
- Address arithmetic is modulo 2^MEM_AW. Wrap past the top of memory is legal and silent.
- abort (any state other than IDLE):
  - Next state is IDLE.
  - FIFO is flushed.
  - An in-flight read is discarded: a 1-cycle ignore flag suppresses its push.
  - done is not pulsed. ready drops in the cycle after abort.
- start and abort in the same cycle: abort wins. In IDLE, that combination starts nothing.
- start in the same cycle as the done pulse is accepted (back-to-back frames).
- Async reset asserted mid-frame: all state clears immediately. No partial beat is ever presented after reset.
- Counters are ceil(log2(N_WORDS+1)) bits wide.

Decomposition:
- Shared package/include: PIX_W and IN_W definitions, the beat pixel-order convention, and FSM state encodings (IDLE=0, FETCH=1, DRAIN=2).
- One sub-module: hog_feed_fifo. Synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/flush/din/dout/count/empty, and first-word-fall-through output.
- FSM, credit logic and counters stay in hog_pixel_feeder.

Test Plan:
1. IMG_W=8, IMG_H=2, base=0x10, request held 1, memory word k = 0x0403_0201 + k*0x04040404 -> beats 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D on 4 consecutive cycles; first ready 2 cycles after start; mem_addr sequence 0x10..0x13; done pulses once; busy drops with done.
2. Same frame, request toggled 1,0,0,1,0,1,1 -> beats only in request=1 cycles, order preserved. mem_rd stalls once fifo_count+inflight=FIFO_D=4; FIFO never overflows.
3. abort 3 cycles after start with request=0 -> ready never asserts; in-flight read discarded; done stays 0. A new start then delivers the frame from word 0.
4. start asserted while busy -> ignored, base_addr unchanged. start in the done cycle with base=0x20 -> second frame reads 0x20..0x23 with no idle beat gap beyond the 2-cycle fill.
5. rst pulled low mid-DRAIN -> ready, busy, done and mem_rd go 0 asynchronously; after release the state is IDLE with the FIFO empty.
6. base=2^17-2, N_WORDS=4 -> mem_addr sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.

Source files
------------

// File: rtl/hog_pixel_feeder_pkg.sv
// Shared definitions for the HOG pixel feeder: pixel sizes, beat layout and FSM encodings.
package hog_pixel_feeder_pkg;

    localparam int HOG_PIX_W        = 8;
    localparam int HOG_PIX_PER_BEAT = 4;
    localparam int HOG_IN_W         = HOG_PIX_PER_BEAT * HOG_PIX_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } feed_state_e;

    // Pixel idx of a beat sits at bits [idx*HOG_PIX_W +: HOG_PIX_W]; pixel 0 is the leftmost.
    function automatic logic [HOG_PIX_W-1:0] beat_pixel(input logic [HOG_IN_W-1:0] beat,
                                                        input logic [1:0]          idx);
        return beat[idx*HOG_PIX_W +: HOG_PIX_W];
    endfunction

endpackage

// File: rtl/hog_feed_fifo.sv
// Small synchronous first-word-fall-through FIFO used to hide pixel memory read latency.
module hog_feed_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop; a push into a full FIFO is accepted only when a pop frees a slot.
    always_comb begin
        do_pop_s  = pop && (count_r != {CW{1'b0}});
        do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
    end

    // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; cleared on reset so the head never shows stale data after power-up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
        end else if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/hog_pixel_feeder.sv
// Streams a stored frame from word-addressed pixel memory into the HOG engine, four pixels per beat.
module hog_pixel_feeder
    import hog_pixel_feeder_pkg::*;
#(
    parameter  int PIX_W   = HOG_PIX_W,
    parameter  int IMG_W   = 640,
    parameter  int IMG_H   = 480,
    parameter  int MEM_AW  = 17,
    parameter  int FIFO_D  = 4,
    localparam int IN_W    = HOG_PIX_PER_BEAT * PIX_W,
    localparam int N_WORDS = IMG_W * IMG_H / 4,
    localparam int CNT_W   = $clog2(N_WORDS + 1),
    localparam int FCW     = $clog2(FIFO_D + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [MEM_AW-1:0] base_addr,
    output logic              mem_rd,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [IN_W-1:0]   mem_rdata,
    input  logic              request,
    output logic              ready,
    output logic [IN_W-1:0]   o_data,
    output logic              busy,
    output logic              done
);

    feed_state_e       state_r;
    feed_state_e       state_s;
    logic [MEM_AW-1:0] base_r;
    logic [CNT_W-1:0]  issue_cnt_r;
    logic [CNT_W-1:0]  sent_cnt_r;
    logic              inflight_r;
    logic              discard_r;
    logic              done_r;
    logic [FCW-1:0]    fifo_count_s;
    logic              fifo_empty_s;
    logic              start_s;
    logic              abort_s;
    logic              credit_ok_s;
    logic              push_s;
    logic              pop_s;

    // Start is honoured only from IDLE and loses to a simultaneous abort; abort is a no-op in IDLE.
    always_comb begin
        start_s     = start && !abort && (state_r == ST_IDLE);
        abort_s     = abort && (state_r != ST_IDLE);
        credit_ok_s = (({1'b0, fifo_count_s} + {{FCW{1'b0}}, inflight_r}) < (FCW+1)'(FIFO_D));
        push_s      = inflight_r && !discard_r;
        pop_s       = ready;
    end

    assign ready = request && !fifo_empty_s;
    assign done  = done_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= ST_IDLE;
        else      state_r <= state_s;
    end

    // FSM next-state: FETCH until the last word is issued, DRAIN until the last beat is taken.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_s = ST_FETCH;
                else         state_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (abort)                                               state_s = ST_IDLE;
                else if (mem_rd && (issue_cnt_r == CNT_W'(N_WORDS - 1))) state_s = ST_DRAIN;
                else                                                     state_s = ST_FETCH;
            end
            ST_DRAIN: begin
                if (abort)                                 state_s = ST_IDLE;
                else if (sent_cnt_r == CNT_W'(N_WORDS))    state_s = ST_IDLE;
                else                                       state_s = ST_DRAIN;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM outputs: reads are issued only while FETCH has a free FIFO credit.
    always_comb begin
        busy     = 1'b0;
        mem_rd   = 1'b0;
        mem_addr = {MEM_AW{1'b0}};
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_FETCH: begin
                busy = 1'b1;
                if (credit_ok_s) begin
                    mem_rd   = 1'b1;
                    mem_addr = base_r + MEM_AW'(issue_cnt_r);
                end else begin
                    mem_rd   = 1'b0;
                    mem_addr = {MEM_AW{1'b0}};
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Frame base and issue/delivery counters, cleared whenever a new frame is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_r      <= {MEM_AW{1'b0}};
            issue_cnt_r <= {CNT_W{1'b0}};
            sent_cnt_r  <= {CNT_W{1'b0}};
        end else if (start_s) begin
            base_r      <= base_addr;
            issue_cnt_r <= {CNT_W{1'b0}};
            sent_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (mem_rd) issue_cnt_r <= issue_cnt_r + CNT_W'(1);
            if (pop_s)  sent_cnt_r  <= sent_cnt_r + CNT_W'(1);
        end
    end

    // Read-return tracking, post-abort discard of the outstanding read, and the done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_r <= 1'b0;
            discard_r  <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            inflight_r <= mem_rd;
            discard_r  <= abort_s;
            done_r     <= (state_r == ST_DRAIN) && !abort && (sent_cnt_r == CNT_W'(N_WORDS));
        end
    end

    hog_feed_fifo #(
        .WIDTH (IN_W),
        .DEPTH (FIFO_D)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .flush (abort_s),
        .din   (mem_rdata),
        .dout  (o_data),
        .count (fifo_count_s),
        .empty (fifo_empty_s)
    );

endmodule
